// File: rtl/read_port_controller.sv
// rtl/read_port_controller.sv - partial-LLR memory read-port address generator with latency-aligned valid/tag stream
// Optional same-cycle write/read bypass flag: define READ_PORT_RAW_BYPASS_EN.
module read_port_controller #(
    parameter int n          = 3,
    parameter int p          = 1,
    parameter int RD_LATENCY = 1,
    parameter int ADDR_WIDTH = $clog2(2**(n-p)-2+p)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   decoder_busy,
    input  logic [$clog2(n)-1:0]   stage_index,
    input  logic [n-p-1:0]         exe_index,
    input  logic                   wr_en,
    input  logic [ADDR_WIDTH-1:0]  wr_addr,
    output logic                   rd_en,
    output logic [ADDR_WIDTH-1:0]  rd_addr,
    output logic                   src_chan,
    output logic                   rd_valid,
    output logic [$clog2(n)-1:0]   rd_stage,
    output logic                   rd_bypass,
    output logic                   busy
);

    localparam int SW  = $clog2(n);
    localparam int AW1 = ADDR_WIDTH + 1;
    localparam int L   = RD_LATENCY;
    // Every pipeline stage except the output one; those entries are still in flight next cycle.
    localparam logic [L-1:0] MID_MASK = {L{1'b1}} >> 1;

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

    state_t                 state_q, state_d;
    logic                   req;
    logic                   req_valid_q, req_valid_d;
    logic                   req_chan_q, req_chan_d;
    logic [SW-1:0]          req_stage_q, req_stage_d;
    logic                   rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0]  rd_addr_q, rd_addr_d;
    logic [L-1:0]           pipe_valid_q, pipe_valid_d;
    logic [L-1:0]           pipe_chan_q, pipe_chan_d;
    logic [L-1:0]           pipe_byp_q, pipe_byp_d;
    logic [L-1:0][SW-1:0]   pipe_stage_q, pipe_stage_d;
    logic [SW:0]            sp;
    logic                   is_chan;
    logic [AW1-1:0]         addr_wide;
    logic                   hazard;
    logic                   in_flight_next;
    logic                   unused_addr_msb;

    assign sp      = {1'b0, stage_index} + (SW+1)'(1);
    assign is_chan = (sp == (SW+1)'(n));

    always_comb begin
        addr_wide = '0;
        if (int'(sp) >= p) begin
            addr_wide = AW1'(2**(n-p)) - (AW1'(1) << (int'(sp) - p)) - AW1'(exe_index);
        end else begin
            addr_wide = AW1'(2**(n-p) - 2 + p) - AW1'(sp);
        end
    end
    assign unused_addr_msb = addr_wide[ADDR_WIDTH];

`ifdef READ_PORT_RAW_BYPASS_EN
    assign hazard = rd_en_q & wr_en & (wr_addr == rd_addr_q);
`else
    logic unused_wr;
    assign unused_wr = ^{wr_en, wr_addr};
    assign hazard    = 1'b0;
`endif

    assign in_flight_next = req_valid_q | (|(pipe_valid_q & MID_MASK));

    always_comb begin
        state_d = state_q;
        req     = 1'b0;
        case (state_q)
            IDLE: begin
                if (decoder_busy) state_d = ACTIVE;
            end
            ACTIVE: begin
                req = en;
                if (!decoder_busy) state_d = DRAIN;
            end
            DRAIN: begin
                if (decoder_busy) state_d = ACTIVE;
                else if (!in_flight_next) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_valid_d = req;
        req_chan_d  = req & is_chan;
        req_stage_d = req ? stage_index : '0;
        rd_en_d     = req & ~is_chan;
        rd_addr_d   = (req && !is_chan) ? addr_wide[ADDR_WIDTH-1:0] : '0;

        pipe_valid_d    = pipe_valid_q;
        pipe_chan_d     = pipe_chan_q;
        pipe_byp_d      = pipe_byp_q;
        pipe_stage_d    = pipe_stage_q;
        pipe_valid_d[0] = req_valid_q;
        pipe_chan_d[0]  = req_chan_q;
        pipe_byp_d[0]   = hazard;
        pipe_stage_d[0] = req_stage_q;
        for (int i = 1; i < L; i++) begin
            pipe_valid_d[i] = pipe_valid_q[i-1];
            pipe_chan_d[i]  = pipe_chan_q[i-1];
            pipe_byp_d[i]   = pipe_byp_q[i-1];
            pipe_stage_d[i] = pipe_stage_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            req_valid_q  <= 1'b0;
            req_chan_q   <= 1'b0;
            req_stage_q  <= '0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            pipe_valid_q <= '0;
            pipe_chan_q  <= '0;
            pipe_byp_q   <= '0;
            pipe_stage_q <= '0;
        end else begin
            state_q      <= state_d;
            req_valid_q  <= req_valid_d;
            req_chan_q   <= req_chan_d;
            req_stage_q  <= req_stage_d;
            rd_en_q      <= rd_en_d;
            rd_addr_q    <= rd_addr_d;
            pipe_valid_q <= pipe_valid_d;
            pipe_chan_q  <= pipe_chan_d;
            pipe_byp_q   <= pipe_byp_d;
            pipe_stage_q <= pipe_stage_d;
        end
    end

    assign rd_en     = rd_en_q;
    assign rd_addr   = rd_addr_q;
    assign rd_valid  = pipe_valid_q[L-1];
    assign src_chan  = pipe_chan_q[L-1];
    assign rd_bypass = pipe_byp_q[L-1];
    assign rd_stage  = pipe_stage_q[L-1];
    assign busy      = (state_q != IDLE);

endmodule

// File: doc/read_port_controller.md
Name: read_port_controller

Overview:
- Read-side address/enable generator for the partial-LLR memory of the SC decoder core; it pairs with the write-port controller on the same memory.
- For each processing-element step it fetches the parent-stage LLR word that feeds the current stage, or flags the channel buffer as the source at the top stage.
- Tracks memory read latency and emits a valid/tag stream aligned to returned data, so the PE array consumes data without its own counters.

Parameters:
- n, 3, log2 of code length N.
- p, 1, log2 of PE parallelism.
- RD_LATENCY, 1, memory read latency in cycles (1..4).
- ADDR_WIDTH, $clog2(2**(n-p)-2+p), memory address width (derived; do not override).

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  step enable from the scheduler.
- decoder_busy  input  1  a codeword is being decoded.
- stage_index  input  $clog2(n)  stage about to be executed.
- exe_index  input  n-p  word index within the parent stage.
- wr_en  input  1  write-port enable, used for the hazard check.
- wr_addr  input  ADDR_WIDTH  write-port address, used for the hazard check.
- rd_en  output  1  memory read enable.
- rd_addr  output  ADDR_WIDTH  memory read address.
- src_chan  output  1  data comes from the channel buffer, not memory; aligned with rd_valid.
- rd_valid  output  1  requested data is present this cycle.
- rd_stage  output  $clog2(n)  stage tag aligned with rd_valid.
- rd_bypass  output  1  data must be taken from the write-data path; aligned with rd_valid.
- busy  output  1  FSM is not IDLE.

Behaviour:
- Reset: all outputs are 0, FSM is IDLE, latency pipeline is cleared.
- Reset asserted mid-operation abandons all in-flight reads immediately. No rd_valid follows deassertion.
- FSM states:
  - IDLE: go to ACTIVE when decoder_busy=1.
  - ACTIVE: go to DRAIN when decoder_busy=0.
  - DRAIN: go to IDLE when the pipeline is empty, at most RD_LATENCY cycles. If decoder_busy rises during DRAIN, go to ACTIVE directly; in-flight entries still complete.
- Request: in ACTIVE with en=1, the cycle-t sample of (stage_index, exe_index) is a request. Outputs are registered and appear at t+1.
- Parent stage sp = stage_index+1. Address arithmetic is computed at ADDR_WIDTH+1 bits, then truncated.
  - stage_index = n-1: rd_en=0, rd_addr=0, request tagged src_chan=1.
  - Otherwise, if sp >= p: rd_addr = 2**(n-p) - 2**(sp-p) - exe_index.
  - Otherwise: rd_addr = 2**(n-p) - 2 + (p-sp).
  - rd_en=1 for memory requests.
- Without a request, rd_en=0 and rd_addr=0.
- Pipeline: shift register of depth RD_LATENCY carrying {valid, src_chan, stage, bypass}, entered at t+1.
  - rd_valid, rd_stage, src_chan and rd_bypass appear at t+1+RD_LATENCY.
  - Throughput is one request per cycle. Back-to-back requests produce back-to-back valids.
- Stage wrap-around needs no special case: stage 0 reads stage 1, and stage n-1 always takes the channel path.

Optional Feature:
- Macro: READ_PORT_RAW_BYPASS_EN.
- Defined: the cycle-t+1 read is hazardous when wr_en=1, rd_en=1 and wr_addr==rd_addr in that cycle. rd_bypass=1 is then delivered with that request's rd_valid.
- Not defined: rd_bypass is constant 0, no comparator is built, and the scheduler must guarantee no same-cycle read/write to one address.

Test Plan:
- Reset: assert rst with busy=1, en=1 -> all outputs 0 the same cycle; after release, rd_valid stays 0 until a new request.
- n=4, p=2, RD_LATENCY=1, stage_index=1, exe_index=0 at t -> t+1: rd_en=1, rd_addr=3; t+2: rd_valid=1, rd_stage=1.
- n=4, p=2, stage_index=0 -> rd_addr=3. stage_index=3 -> rd_en=0, then src_chan=1 and rd_valid=1 at t+2.
- n=3, p=1, RD_LATENCY=3, four back-to-back stage_index=0 requests with exe_index 0..3 -> rd_addr 3,2,1,0 on consecutive cycles; rd_valid high four cycles starting at t+4.
- Drop decoder_busy in the cycle after the last request -> busy stays 1 through DRAIN until the final rd_valid, then returns to 0.
- With READ_PORT_RAW_BYPASS_EN, wr_en=1 and wr_addr=3 in the same cycle as rd_addr=3 -> rd_bypass=1 with that rd_valid. With wr_addr=2 -> rd_bypass=0.
